store_buffer: RTL and testbench

Posted-write store buffer between the pipelined RISC-V core's memory stage and the data-memory bus. Captures each store the core issues (MemWrite, DataAdr, WriteData), queues it in order in a small FIFO, and drains it to memory through a valid/ready handshake. The core can retire stores without waiting on a slow memory. Loads that hit a pending store are either forwarded the buffered data or stalled, depending on configuration.

---
 rtl/store_buffer_if.sv | 29 ++
 rtl/store_buffer.sv | 101 ++++++++++
 tb/tb_store_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Core/memory-side signal bundle for the posted-write store buffer.
// slave = the buffer itself; master = the core plus memory bus driving it.
interface store_buffer_if #(
   parameter int DEPTH = 4
);
   logic                     MemWrite;
   logic                     MemRead;
   logic [31:0]              DataAdr;
   logic [31:0]              WriteData;
   logic                     Stall;
   logic                     FwdHit;
   logic [31:0]              FwdData;
   logic                     BusValid;
   logic                     BusReady;
   logic [31:0]              BusAdr;
   logic [31:0]              BusWData;
   logic                     Empty;
   logic [$clog2(DEPTH):0]   Count;

   modport master (
      output MemWrite, MemRead, DataAdr, WriteData, BusReady,
      input  Stall, FwdHit, FwdData, BusValid, BusAdr, BusWData, Empty, Count
   );

   modport slave (
      input  MemWrite, MemRead, DataAdr, WriteData, BusReady,
      output Stall, FwdHit, FwdData, BusValid, BusAdr, BusWData, Empty, Count
   );
endinterface

// File: rtl/store_buffer.sv
// In-order posted-write store buffer with load-hit detection.
// Define STORE_FWD_EN to forward the youngest matching store to loads instead of stalling them.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           reset,
   store_buffer_if.slave sb
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      adr_q  [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty_q, empty_d;

   logic             load, full, hit, push, pop, stall;
   logic [PTR_W-1:0] idx;
`ifdef STORE_FWD_EN
   logic [31:0]      fwd_data;
`endif

   assign load = sb.MemRead & ~sb.MemWrite;
   assign full = (count_q == CNT_W'(DEPTH));

   // Walk entries oldest to youngest so the last match is the youngest store.
   always_comb begin
      hit = 1'b0;
      idx = '0;
`ifdef STORE_FWD_EN
      fwd_data = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         idx = rptr_q + PTR_W'(k);
         if (load && (CNT_W'(k) < count_q) && (adr_q[idx][31:2] == sb.DataAdr[31:2])) begin
            hit = 1'b1;
`ifdef STORE_FWD_EN
            fwd_data = data_q[idx];
`endif
         end
      end
   end

   always_comb begin
`ifdef STORE_FWD_EN
      stall      = sb.MemWrite & full;
      sb.FwdHit  = hit;
      sb.FwdData = fwd_data;
`else
      stall      = (sb.MemWrite & full) | (load & hit);
      sb.FwdHit  = 1'b0;
      sb.FwdData = '0;
`endif
   end

   // A full buffer stalls even when the head drains this cycle.
   assign push = sb.MemWrite & ~stall;
   assign pop  = ~empty_q & sb.BusReady;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_W'(1);
         if (pop)  rptr_q <= rptr_q + PTR_W'(1);
         count_q <= count_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         adr_q[wptr_q]  <= sb.DataAdr;
         data_q[wptr_q] <= sb.WriteData;
      end
   end

   always_comb begin
      sb.Stall    = stall;
      sb.Empty    = empty_q;
      sb.Count    = count_q;
      sb.BusValid = ~empty_q;
      sb.BusAdr   = empty_q ? 32'd0 : adr_q[rptr_q];
      sb.BusWData = empty_q ? 32'd0 : data_q[rptr_q];
   end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue model checked every cycle plus literal expectations.
module tb_store_buffer;
   localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } ent_t;

   logic clk;
   logic reset;
   store_buffer_if #(.DEPTH(DEPTH)) sb ();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_chk  = 0;
   int          n_fail = 0;
   bit          en     = 1'b0;
   ent_t        q[$];
   logic [31:0] bus_log[$];
   bit          m_st, m_pu, m_po;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_hit();
      if (!(sb.MemRead && !sb.MemWrite)) return 1'b0;
      foreach (q[i]) if (q[i].adr[31:2] == sb.DataAdr[31:2]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_fwd();
      if (!FWD || !m_hit()) return 32'd0;
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].adr[31:2] == sb.DataAdr[31:2]) return q[i].dat;
      return 32'd0;
   endfunction

   function automatic bit m_stall();
      return (sb.MemWrite && q.size() == DEPTH) || (!FWD && m_hit());
   endfunction

   // Model state advance: pop the old head, then append the new store.
   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         en = 1'b1;
      end else if (en) begin
         m_st = m_stall();
         m_pu = sb.MemWrite && !m_st;
         m_po = (q.size() != 0) && sb.BusReady;
         if (m_po) void'(q.pop_front());
         if (m_pu) q.push_back('{adr: sb.DataAdr, dat: sb.WriteData});
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("Count",    32'(sb.Count),    32'(q.size()));
         chk("Empty",    32'(sb.Empty),    32'(q.size() == 0));
         chk("BusValid", 32'(sb.BusValid), 32'(q.size() != 0));
         chk("BusAdr",   sb.BusAdr,        (q.size() != 0) ? q[0].adr : 32'd0);
         chk("BusWData", sb.BusWData,      (q.size() != 0) ? q[0].dat : 32'd0);
         chk("Stall",    32'(sb.Stall),    32'(m_stall()));
         chk("FwdHit",   32'(sb.FwdHit),   32'(FWD && m_hit()));
         chk("FwdData",  sb.FwdData,       m_fwd());
         if (sb.BusValid === 1'b1 && sb.BusReady) bus_log.push_back(sb.BusAdr);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      sb.MemWrite  = 1'b1;
      sb.MemRead   = 1'b0;
      sb.DataAdr   = a;
      sb.WriteData = d;
   endtask

   task automatic idle();
      sb.MemWrite = 1'b0;
      sb.MemRead  = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_order [5];
      exp_order = '{32'd96, 32'd100, 32'd104, 32'd108, 32'd112};

      reset        = 1'b1;
      sb.MemWrite  = 1'b0;
      sb.MemRead   = 1'b0;
      sb.DataAdr   = '0;
      sb.WriteData = '0;
      sb.BusReady  = 1'b0;
      cyc(2);
      reset = 1'b0;
      #2;
      chk("rst Count",    32'(sb.Count),    32'd0);
      chk("rst Empty",    32'(sb.Empty),    32'd1);
      chk("rst BusValid", 32'(sb.BusValid), 32'd0);
      chk("rst BusAdr",   sb.BusAdr,        32'd0);
      chk("rst Stall",    32'(sb.Stall),    32'd0);
      chk("rst FwdData",  sb.FwdData,       32'd0);

      // Single store, one-cycle latency to the bus.
      sb.BusReady = 1'b1;
      store(32'd100, 32'd25);
      cyc();
      idle();
      #2;
      chk("single BusValid", 32'(sb.BusValid), 32'd1);
      chk("single BusAdr",   sb.BusAdr,        32'd100);
      chk("single BusWData", sb.BusWData,      32'd25);
      cyc();
      #2;
      chk("single Empty", 32'(sb.Empty), 32'd1);

      // Fill, then stall the fifth store until a drain frees a slot.
      bus_log.delete();
      sb.BusReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         store(32'd96 + 32'(4 * i), 32'(i + 1));
         cyc();
      end
      store(32'd112, 32'd5);
      #2;
      chk("full Count", 32'(sb.Count), 32'd4);
      chk("full Stall", 32'(sb.Stall), 32'd1);
      cyc();
      sb.BusReady = 1'b1;
      #2;
      chk("full drain Stall", 32'(sb.Stall), 32'd1);
      cyc();
      sb.BusReady = 1'b0;
      #2;
      chk("after pop Stall", 32'(sb.Stall), 32'd0);
      chk("after pop Count", 32'(sb.Count), 32'd3);
      cyc();
      idle();
      #2;
      chk("refill Count", 32'(sb.Count), 32'd4);

      // Back-pressure hold, then in-order drain.
      for (int i = 0; i < 5; i++) begin
         chk("hold BusAdr",   sb.BusAdr,   32'd100);
         chk("hold BusWData", sb.BusWData, 32'd2);
         cyc();
         #2;
      end
      sb.BusReady = 1'b1;
      cyc(4);
      #2;
      chk("drain Empty", 32'(sb.Empty), 32'd1);
      chk("drain log size", 32'(bus_log.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         chk("drain order", (i < bus_log.size()) ? bus_log[i] : 32'hFFFF_FFFF, exp_order[i]);

      // Load hit: forwarding or stalling, depending on build.
      sb.BusReady = 1'b0;
      store(32'd100, 32'd7);
      cyc();
      store(32'd100, 32'd25);
      cyc();
      sb.MemWrite = 1'b0;
      sb.MemRead  = 1'b1;
      sb.DataAdr  = 32'd102;
      #2;
      if (FWD) begin
         chk("fwd FwdHit",  32'(sb.FwdHit), 32'd1);
         chk("fwd FwdData", sb.FwdData,     32'd25);
         chk("fwd Stall",   32'(sb.Stall),  32'd0);
         sb.DataAdr = 32'd200;
         #1;
         chk("fwd miss FwdHit", 32'(sb.FwdHit), 32'd0);
      end else begin
         chk("nofwd Stall",  32'(sb.Stall),  32'd1);
         chk("nofwd FwdHit", 32'(sb.FwdHit), 32'd0);
         cyc(2);
         sb.BusReady = 1'b1;
         #2;
         chk("nofwd Stall while 1st drains", 32'(sb.Stall), 32'd1);
         cyc();
         #2;
         chk("nofwd Stall while 2nd drains", 32'(sb.Stall), 32'd1);
         cyc();
         #2;
         chk("nofwd Stall released", 32'(sb.Stall), 32'd0);
      end
      idle();
      sb.BusReady = 1'b1;
      cyc(3);

      // Load and store together behaves as a store with no match.
      sb.BusReady  = 1'b0;
      store(32'd100, 32'd9);
      sb.MemRead   = 1'b1;
      cyc();
      #2;
      chk("rw Count", 32'(sb.Count), 32'd1);
      sb.MemWrite = 1'b0;
      #1;
      chk("rw load hit Stall", 32'(sb.Stall), 32'(!FWD));
      idle();
      sb.BusReady = 1'b1;
      cyc();

      // Back-to-back stores at full throughput.
      for (int i = 0; i < 6; i++) begin
         store(32'h1000 + 32'(4 * i), 32'(100 + i));
         cyc();
      end
      idle();
      #2;
      chk("stream Count", 32'(sb.Count), 32'd1);
      cyc();

      // Reset in the middle of a drain discards everything.
      sb.BusReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         store(32'h2000 + 32'(4 * i), 32'(i));
         cyc();
      end
      idle();
      #2;
      chk("pre-reset BusValid", 32'(sb.BusValid), 32'd1);
      chk("pre-reset Count",    32'(sb.Count),    32'd3);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #2;
      chk("mid-reset BusValid", 32'(sb.BusValid), 32'd0);
      chk("mid-reset Count",    32'(sb.Count),    32'd0);
      chk("mid-reset Empty",    32'(sb.Empty),    32'd1);
      bus_log.delete();
      sb.BusReady = 1'b1;
      cyc(4);
      chk("no writes after reset", 32'(bus_log.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
